// File: rtl/ps_if.sv
// ps_if: write and read channel bundle between a ps_if master and a register slave
interface ps_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] waddr, raddr;
    logic [DATA_WIDTH-1:0] wdata, rdata;
    logic wvalid, wready, wresp, arvalid, rvalid, rready;
    modport master (
        output waddr, wdata, wvalid, raddr, arvalid, rready,
        input  wready, wresp, rdata, rvalid
    );
    modport slave (
        input  waddr, wdata, wvalid, raddr, arvalid, rready,
        output wready, wresp, rdata, rvalid
    );
endinterface

// File: rtl/ps_reg_slave.sv
// ps_reg_slave: register bank on the slave side of ps_if with FIFO-buffered read responses
module ps_reg_slave #(
    parameter int                  ADDR_WIDTH = 5,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
    parameter int                  RD_DEPTH   = 4
) (
    input  logic clk,
    input  logic rst,
    ps_if.slave  bus,
    output logic rd_ovf
);
    localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam int PW = $clog2(RD_DEPTH);
    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    wstate_t state, state_n;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] fifo [RD_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0] cnt;
    logic [IW-1:0] widx, ridx;
    logic [DATA_WIDTH-1:0] rd_val;
    logic w_in, r_in, w_commit, push, pop, full;
    assign widx = bus.waddr[IW-1:0];
    assign ridx = bus.raddr[IW-1:0];
    assign w_in = {1'b0, bus.waddr} < (ADDR_WIDTH+1)'(NUM_REGS);
    assign r_in = {1'b0, bus.raddr} < (ADDR_WIDTH+1)'(NUM_REGS);
    assign w_commit = state == W_IDLE && bus.wvalid && w_in && !RO_MASK[widx];
    // read samples the pre-write value, so same-cycle read/write returns old data
    assign rd_val = r_in ? regs[ridx] : '0;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= W_IDLE;
        else state <= state_n;
    always_comb state_n = state == W_IDLE && bus.wvalid ? W_RESP : W_IDLE;
    always_comb begin
        bus.wready = state == W_IDLE && !rst;
        bus.wresp  = state == W_RESP;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        else if (w_commit) regs[widx] <= bus.wdata;
    // a pop in the same cycle frees the slot, so a full FIFO can still take a push
    assign pop  = bus.rvalid && bus.rready;
    assign full = cnt == (PW+1)'(RD_DEPTH) && !pop;
    assign push = bus.arvalid && !full;
    assign bus.rvalid = cnt != '0;
    assign bus.rdata  = bus.rvalid ? fifo[rp] : '0;
    always_ff @(posedge clk)
        if (push) fifo[wp] <= rd_val;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp     <= '0;
            rp     <= '0;
            cnt    <= '0;
            rd_ovf <= 1'b0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop) rp <= rp + PW'(1);
            cnt    <= cnt + (PW+1)'(push) - (PW+1)'(pop);
            rd_ovf <= rd_ovf | (bus.arvalid && full);
        end
endmodule

// File: tb/tb_ps_reg_slave.sv
// tb_ps_reg_slave: randomized and directed stimulus with a queue-based scoreboard for ps_reg_slave
module tb_ps_reg_slave;
    localparam int AW = 5, DW = 32, NR = 16, RD = 4;
    localparam logic [NR-1:0] RO = 16'h0001;
    logic clk = 0, rst = 1;
    logic rd_ovf;
    int checks = 0, errors = 0;
    int cyc = 0;
    ps_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    ps_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO), .RD_DEPTH(RD)) dut (
        .clk(clk), .rst(rst), .bus(bus), .rd_ovf(rd_ovf)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    logic [DW-1:0] m_regs [NR];
    logic [DW-1:0] rq [$];
    int wq [$];
    int m_vis = 0;
    logic m_wready = 1, m_busy = 0, m_busy_n = 0, m_ovf = 0, m_ovf_n = 0;

    function automatic logic [DW-1:0] rd_model(input int a);
        return a < NR ? m_regs[a] : '0;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // scoreboard monitor: mid-cycle, compares DUT outputs with the model queues
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_wready", bus.wready, 0);
            chk("rst_wresp", bus.wresp, 0);
            chk("rst_rvalid", bus.rvalid, 0);
            chk("rst_rdata", bus.rdata, 0);
            chk("rst_rd_ovf", rd_ovf, 0);
        end else begin
            chk("wready", bus.wready, m_wready);
            chk("rd_ovf", rd_ovf, m_ovf);
            chk("rvalid", bus.rvalid, m_vis > 0);
            if (bus.rvalid && rq.size() > 0) begin
                chk("rdata", bus.rdata, rq[0]);
                if (bus.rready) void'(rq.pop_front());
            end
            if (bus.wresp) begin
                chk("wresp_cycle", wq.size() > 0 ? wq[0] : -1, cyc);
                if (wq.size() > 0) void'(wq.pop_front());
            end else if (wq.size() > 0 && wq[0] <= cyc) begin
                chk("wresp", bus.wresp, 1);
                void'(wq.pop_front());
            end
        end
    end

    task automatic step(input logic wv, input int wa, input logic [DW-1:0] wd,
                        input logic av, input int ra, input logic rr);
        logic p, f;
        @(posedge clk);
        #1;
        bus.wvalid = wv; bus.waddr = AW'(wa); bus.wdata = wd;
        bus.arvalid = av; bus.raddr = AW'(ra); bus.rready = rr;
        m_busy = m_busy_n;
        m_ovf = m_ovf_n;
        m_wready = !m_busy;
        m_vis = rq.size();
        p = m_vis > 0 && rr;
        f = m_vis == RD && !p;
        if (av) begin
            if (f) m_ovf_n = 1;
            else rq.push_back(rd_model(ra));
        end
        if (wv && !m_busy) begin
            if (wa < NR && !RO[4'(wa)]) m_regs[wa] = wd;
            wq.push_back(cyc + 1);
        end
        m_busy_n = wv && !m_busy;
    endtask

    task automatic do_reset();
        rst = 1;
        bus.wvalid = 0; bus.waddr = 0; bus.wdata = 0;
        bus.arvalid = 0; bus.raddr = 0; bus.rready = 0;
        rq.delete();
        wq.delete();
        foreach (m_regs[i]) m_regs[i] = '0;
        m_busy = 0; m_busy_n = 0; m_ovf = 0; m_ovf_n = 0; m_wready = 1; m_vis = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic drain(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        do_reset();
        step(1, 3, 32'hDEADBEEF, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 3, 0);
        step(0, 0, 0, 0, 0, 0);
        drain(3);
        step(1, 0, 32'h1234, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        step(1, 20, 32'h99, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 20, 1);
        drain(3);
        for (int i = 1; i <= 4; i++) begin
            step(1, i, 32'(i * 'h11), 0, 0, 1);
            step(0, 0, 0, 0, 0, 1);
        end
        for (int i = 1; i <= 5; i++) step(0, 0, 0, 1, i, 0);
        step(0, 0, 0, 0, 0, 0);
        drain(6);
        step(1, 5, 32'h55, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(1, 5, 32'hAA, 1, 5, 1);
        step(0, 0, 0, 1, 5, 1);
        drain(3);
        for (int i = 0; i < 4; i++) begin
            step(1, 6 + i, 32'h100 + 32'(i), 0, 0, 1);
            step(1, 7 + i, 32'h100 + 32'(i + 1), 0, 0, 1);
        end
        for (int i = 6; i < 10; i++) step(0, 0, 0, 1, i, 1);
        drain(3);
        for (int n = 0; n < 400; n++)
            step(1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0 ? $urandom_range(16, 31) : $urandom_range(0, 15),
                 $urandom,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0 ? $urandom_range(16, 31) : $urandom_range(0, 15),
                 $urandom_range(0, 3) != 0);
        drain(6);
        for (int i = 1; i <= 5; i++) step(0, 0, 0, 1, i, 0);
        step(0, 0, 0, 1, 3, 0);
        step(1, 7, 32'h77, 1, 4, 0);
        step(0, 0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < NR; i++) step(0, 0, 0, 1, i, 1);
        drain(6);
        chk("rq_empty", rq.size(), 0);
        chk("wq_empty", wq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
